// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path.
//   seg7_t           : seven-bit segment vector {g,f,e,d,c,b,a}, bit 0 = a
//   SEG_0 .. SEG_9   : digit patterns, active-low (0 = segment lit)
//   SEG_BLANK        : every segment dark (active-low)
//   SEG_ALL_ON       : every segment lit (active-low)
//   BCD_MAX          : largest legal BCD code
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0      = 7'b1000000;
    localparam seg7_t SEG_1      = 7'b1111001;
    localparam seg7_t SEG_2      = 7'b0100100;
    localparam seg7_t SEG_3      = 7'b0110000;
    localparam seg7_t SEG_4      = 7'b0011001;
    localparam seg7_t SEG_5      = 7'b0010010;
    localparam seg7_t SEG_6      = 7'b0000010;
    localparam seg7_t SEG_7      = 7'b1111000;
    localparam seg7_t SEG_8      = 7'b0000000;
    localparam seg7_t SEG_9      = 7'b0010000;
    localparam seg7_t SEG_BLANK  = 7'b1111111;
    localparam seg7_t SEG_ALL_ON = 7'b0000000;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_seg_lut.sv
// ---------------------------------------------------------------------------
// bcd_seg_lut
// Purely combinational BCD digit lookup. Produces the segment pattern in
// "lit = 1" form so the caller can apply whatever output polarity it needs.
//   bcd     in  [3:0] : BCD code, 0-9 legal
//   lit     out [6:0] : {g..a}, 1 = segment lit; all zero for illegal codes
//   invalid out       : 1 when bcd is 10-15
// ---------------------------------------------------------------------------
module bcd_seg_lut
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] lit,
    output logic       invalid
);

    always_comb begin
        lit     = '0;
        invalid = (bcd > BCD_MAX);
        // Table constants are active-low, so invert them into lit-high form.
        case (bcd)
            4'd0:    lit = ~SEG_0;
            4'd1:    lit = ~SEG_1;
            4'd2:    lit = ~SEG_2;
            4'd3:    lit = ~SEG_3;
            4'd4:    lit = ~SEG_4;
            4'd5:    lit = ~SEG_5;
            4'd6:    lit = ~SEG_6;
            4'd7:    lit = ~SEG_7;
            4'd8:    lit = ~SEG_8;
            4'd9:    lit = ~SEG_9;
            default: lit = '0;
        endcase
    end

endmodule

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Registered BCD to seven-segment decoder with lamp test, leading-zero
// ripple blanking and an invalid-code flag. One cycle of latency.
//   ACTIVE_LOW        : 1 = lit segment driven 0 (common anode), 0 = inverted
//   clk       in      : rising-edge clock
//   rst_n     in      : asynchronous active-low reset
//   bcd_in    in [3:0]: BCD digit, 10-15 flagged invalid
//   lamp_test in      : light every segment
//   rbi       in      : ripple-blank in, suppresses a zero digit
//   seg_out   out[6:0]: {g,f,e,d,c,b,a}
//   rbo       out     : this digit was zero-suppressed
//   invalid   out     : registered code was 10-15
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd_in,
    input  logic       lamp_test,
    input  logic       rbi,
    output logic [6:0] seg_out,
    output logic       rbo,
    output logic       invalid
);

    // Blank display in whichever polarity the pins use.
    localparam seg7_t SEG_RESET = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    logic [6:0] lut_lit;
    logic       lut_invalid;

    logic [6:0] lit_next;
    logic [6:0] seg_next;
    logic       rbo_next;
    logic       invalid_next;

    logic [6:0] seg_reg;
    logic       rbo_reg;
    logic       invalid_reg;

    bcd_seg_lut u_lut (
        .bcd     (bcd_in),
        .lit     (lut_lit),
        .invalid (lut_invalid)
    );

    // Priority: lamp test > invalid code > ripple blank > normal digit.
    // The invalid flag follows the input code even during lamp test.
    always_comb begin
        lit_next     = lut_lit;
        rbo_next     = 1'b0;
        invalid_next = lut_invalid;
        if (lamp_test) begin
            lit_next = '1;
        end else if (lut_invalid) begin
            lit_next = '0;
        end else if ((bcd_in == 4'd0) && rbi) begin
            lit_next = '0;
            rbo_next = 1'b1;
        end
    end

    // Per-segment polarity select.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_polarity
            assign seg_next[gi] = ACTIVE_LOW ? ~lit_next[gi] : lit_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg     <= SEG_RESET;
            rbo_reg     <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            seg_reg     <= seg_next;
            rbo_reg     <= rbo_next;
            invalid_reg <= invalid_next;
        end
    end

    assign seg_out = seg_reg;
    assign rbo     = rbo_reg;
    assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_7seg
// Scoreboard bench: the driver pushes the expected response of each stimulus
// into a queue, the monitor pops and compares one cycle later. Two decoders
// share the inputs, one per output polarity. The reference model describes
// each digit by the names of its lit segments.
// ---------------------------------------------------------------------------
module tb_bcd_to_7seg;

    typedef struct packed {
        logic [6:0] lit;   // 1 = segment lit, {g..a}
        logic       rbo;
        logic       inv;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd_in;
    logic       lamp_test;
    logic       rbi;
    logic [6:0] seg_lo;
    logic       rbo_lo;
    logic       inv_lo;
    logic [6:0] seg_hi;
    logic       rbo_hi;
    logic       inv_hi;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    string lit_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    bcd_to_7seg #(.ACTIVE_LOW(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .lamp_test (lamp_test),
        .rbi       (rbi),
        .seg_out   (seg_lo),
        .rbo       (rbo_lo),
        .invalid   (inv_lo)
    );

    bcd_to_7seg #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .lamp_test (lamp_test),
        .rbi       (rbi),
        .seg_out   (seg_hi),
        .rbo       (rbo_hi),
        .invalid   (inv_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digit_lit(int d);
        logic [6:0] m;
        string      s;
        m = '0;
        s = lit_names[d];
        for (int i = 0; i < s.len(); i++) begin
            m[s[i] - 8'd97] = 1'b1;
        end
        return m;
    endfunction

    function automatic exp_t model(int d, bit lt, bit rb);
        exp_t e;
        e.lit = '0;
        e.rbo = 1'b0;
        e.inv = (d > 9);
        if (lt)                 e.lit = 7'h7f;
        else if (d > 9)         e.lit = '0;
        else if (d == 0 && rb)  e.rbo = 1'b1;
        else                    e.lit = digit_lit(d);
        return e;
    endfunction

    task automatic check(string name, logic [6:0] act, logic [6:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    task automatic drive(int d, bit lt, bit rb);
        @(negedge clk);
        bcd_in    = 4'(d);
        lamp_test = lt;
        rbi       = rb;
        exp_q.push_back(model(d, lt, rb));
        $display("stim bcd=%0d lt=%0b rbi=%0b", d, lt, rb);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_seg_lo"}, seg_lo, 7'b1111111);
        check({tag, "_rbo_lo"}, {6'd0, rbo_lo}, 7'd0);
        check({tag, "_inv_lo"}, {6'd0, inv_lo}, 7'd0);
        check({tag, "_seg_hi"}, seg_hi, 7'b0000000);
        check({tag, "_rbo_hi"}, {6'd0, rbo_hi}, 7'd0);
        check({tag, "_inv_hi"}, {6'd0, inv_hi}, 7'd0);
    endtask

    // Monitor: outputs update every cycle, so one expected entry per edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("seg_lo", seg_lo, ~e.lit);
            check("rbo_lo", {6'd0, rbo_lo}, {6'd0, e.rbo});
            check("inv_lo", {6'd0, inv_lo}, {6'd0, e.inv});
            check("seg_hi", seg_hi, e.lit);
            check("rbo_hi", {6'd0, rbo_hi}, {6'd0, e.rbo});
            check("inv_hi", {6'd0, inv_hi}, {6'd0, e.inv});
            $display("resp seg_lo=%b seg_hi=%b rbo=%0b inv=%0b", seg_lo, seg_hi, rbo_lo, inv_lo);
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        bcd_in    = 4'd8;
        lamp_test = 1'b0;
        rbi       = 1'b0;

        // Power-on reset with the clock running.
        #2 rst_n = 1'b0;
        #1 check_reset("por_async");
        @(posedge clk); #1;
        check_reset("por_clocked");
        @(posedge clk); #1;
        check_reset("por_clocked2");

        // Release together with the first stimulus.
        @(negedge clk);
        rst_n = 1'b1;
        bcd_in = 4'd0; lamp_test = 1'b0; rbi = 1'b0;
        exp_q.push_back(model(0, 0, 0));

        for (int d = 1; d <= 9; d++) drive(d, 0, 0);
        drive(10, 0, 0);
        drive(15, 0, 0);
        drive(3, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(5, 0, 1);
        drive(12, 1, 0);
        drive(12, 0, 0);
        drive(8, 0, 0);

        // Mid-stream reset: a new digit is applied, then reset lands before
        // the edge that would sample it.
        @(negedge clk);
        bcd_in = 4'd2;
        #2 rst_n = 1'b0;
        #1 check_reset("mid_async");
        @(posedge clk); #1;
        check_reset("mid_clocked");
        @(negedge clk);
        rst_n = 1'b1;
        bcd_in = 4'd7; lamp_test = 1'b0; rbi = 1'b1;
        exp_q.push_back(model(7, 0, 1));

        for (int n = 0; n < 200; n++) begin
            drive(int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0),
                  bit'($urandom_range(0, 1)));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_7seg.md
# bcd_to_7seg

Registered BCD-to-seven-segment decoder for numeric display digits. Converts one 4-bit BCD digit into seven segment drive lines, with lamp test, leading-zero ripple blanking, and an invalid-code flag. Sits between digit-generation logic (counters, binary-to-BCD) and the display pins or the digit multiplexer.

## Interface
- `ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0 (common-anode); 0 inverts all seven segment outputs.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `bcd_in` input, 4 bits: BCD digit; 0–9 valid, 10–15 invalid.
- `lamp_test` input, 1 bit: 1 lights all segments.
- `rbi` input, 1 bit: ripple-blank in; 1 suppresses a zero digit.
- `seg_out` output, 7 bits: segment drive {g,f,e,d,c,b,a}; bit 0 is a, bit 6 is g.
- `rbo` output, 1 bit: ripple-blank out; 1 when this digit was zero-suppressed.
- `invalid` output, 1 bit: 1 when the registered input code was 10–15.

## Operation
- Segment patterns are listed active-low ({g..a}, `ACTIVE_LOW`=1):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- BLANK = 1111111; ALL_ON = 0000000.
- With `ACTIVE_LOW`=0, every pattern is bitwise inverted.
- Next-state priority, highest first:
  1. `lamp_test`=1: seg=ALL_ON, rbo=0. `invalid` still reflects `bcd_in`.
  2. `bcd_in` 10–15: seg=BLANK, invalid=1, rbo=0.
  3. `bcd_in`=0 and `rbi`=1: seg=BLANK, rbo=1, invalid=0.
  4. Otherwise: seg=pattern(`bcd_in`), rbo=0, invalid=0.
- No internal state beyond the output registers; the decode is a pure function of the current inputs.

## Timing
- All outputs are registered and update on the rising edge of `clk`.
- Latency: 1 cycle from input change to output. Inputs are sampled only at the clock edge.
- Reset (asynchronous, active-low):
  - seg_out=BLANK (polarity per `ACTIVE_LOW`), rbo=0, invalid=0.
  - Outputs take these values immediately on `rst_n` falling, independent of `clk`.
  - Release is synchronous in effect: the first decode lands on the first rising edge after `rst_n`=1.
  - Reset asserted mid-stream discards the in-flight value; no stale digit appears after release.
- Back-to-back input changes each produce their own output on consecutive cycles; none are dropped.
- `rbi` chains left to right across digits. Each stage's `rbo` is registered, so an N-digit chain settles in N cycles after a change.

## Structure
- Shared package `seg7_pkg`:
  - seven-bit segment typedef
  - active-low pattern constants SEG_0..SEG_9, SEG_BLANK, SEG_ALL_ON
- One combinational sub-module `bcd_seg_lut` (bcd → active-high-lit pattern, plus invalid flag). The top module applies priority, polarity and the registers.

## Test plan
- Reset held low, clock running: seg_out=1111111, rbo=0, invalid=0. Asserting `rst_n` low mid-stream forces these values immediately, without a clock edge.
- Sweep `bcd_in` 0..9 with lamp_test=0, rbi=0, one value per cycle: each seg_out matches the table one cycle later (e.g. 4 → 0011001, 8 → 0000000).
- `bcd_in`=10 and then 15: seg_out=1111111, invalid=1. Next `bcd_in`=3: seg_out=0110000, invalid=0.
- Ripple blanking:
  - `bcd_in`=0, rbi=1 → seg_out=1111111, rbo=1.
  - `bcd_in`=0, rbi=0 → 1000000, rbo=0.
  - `bcd_in`=5, rbi=1 → 0010010, rbo=0.
- `lamp_test`=1 with `bcd_in`=12: seg_out=0000000, invalid=1. Release → 1111111.
- With `ACTIVE_LOW`=0, `bcd_in`=1 → seg_out=0000110; reset value is 0000000.
